// File: rtl/core_ctrl_pkg.sv
// Shared types and instruction-word layout for the attention-core sequencer.
package core_ctrl_pkg;

  localparam int INST_W = 17;

  // Bit positions inside the instruction word
  localparam int OFIFO_RD   = 16;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB  = 8;
  localparam int EXEC       = 7;
  localparam int KLOAD      = 6;
  localparam int QRD        = 5;
  localparam int QWR        = 4;
  localparam int KRD        = 3;
  localparam int KWR        = 2;
  localparam int PRD        = 1;
  localparam int PWR        = 0;

  // State names carry an ST_ prefix so they do not clash with the bit names above
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_KWR,
    ST_QWR,
    ST_KLD,
    ST_KLD_T,
    ST_EXE,
    ST_EXE_T,
    ST_DRN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/core_ctrl_cnt.sv
// Up-counter with synchronous clear, enable and a terminal compare against a limit.
module core_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  // Clear wins over enable so a state change always starts the next state at index 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= cnt + W'(1);
  end

  assign last = (cnt == limit);

endmodule

// File: rtl/core_ctrl.sv
// Instruction sequencer for the attention core: K/Q load, kernel load, execute, drain.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int IW     = INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_k,
  input  logic [ADDR_W-1:0] num_q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ofifo_valid,
  output logic [IW-1:0]     inst,
  output logic              busy,
  output logic              done
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   nk, nq;
  logic [ADDR_W-1:0]   i, limit;
  logic                last, inc, clr;

  // State register and vector counts captured when a pass is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      nk    <= '0;
      nq    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        nk <= num_k;
        nq <= num_q;
      end
    end
  end

  // K-side states compare against the K count, everything else against Q
  assign limit = (state == ST_KWR || state == ST_KLD) ? nk : nq;
  assign clr   = (state_nxt != state);

  core_ctrl_cnt #(.W(ADDR_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (inc),
    .limit (limit),
    .cnt   (i),
    .last  (last)
  );

  // Next state and instruction decode; only in_valid and ofifo_valid feed outputs directly
  always_comb begin
    state_nxt = state;
    inst      = '0;
    in_ready  = 1'b0;
    done      = 1'b0;
    inc       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_KWR;
      end
      ST_KWR: begin
        in_ready                      = 1'b1;
        inst[QK_ADD_LSB +: ADDR_W]    = i;
        inst[KWR]                     = in_valid;
        inc                           = in_valid;
        if (in_valid && last) state_nxt = ST_QWR;
      end
      ST_QWR: begin
        in_ready                      = 1'b1;
        inst[QK_ADD_LSB +: ADDR_W]    = i;
        inst[QWR]                     = in_valid;
        inc                           = in_valid;
        if (in_valid && last) state_nxt = ST_KLD;
      end
      ST_KLD: begin
        inst[QK_ADD_LSB +: ADDR_W]    = i;
        inst[KRD]                     = 1'b1;
        inst[KLOAD]                   = 1'b1;
        inc                           = 1'b1;
        if (last) state_nxt = ST_KLD_T;
      end
      // Holds the kernel-load select one extra cycle for the SRAM read latency
      ST_KLD_T: begin
        inst[KLOAD] = 1'b1;
        state_nxt   = ST_EXE;
      end
      ST_EXE: begin
        inst[QK_ADD_LSB +: ADDR_W]    = i;
        inst[QRD]                     = 1'b1;
        inst[EXEC]                    = 1'b1;
        inc                           = 1'b1;
        if (last) state_nxt = ST_EXE_T;
      end
      ST_EXE_T: begin
        inst[EXEC] = 1'b1;
        state_nxt  = ST_DRN;
      end
      // FIFO head is already on fifo_out, so read and psum write share a cycle
      ST_DRN: begin
        inst[P_ADD_LSB +: ADDR_W]     = i;
        inst[OFIFO_RD]                = ofifo_valid;
        inst[PWR]                     = ofifo_valid;
        inc                           = ofifo_valid;
        if (ofifo_valid && last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: stall-free passes, handshake stalls, ignored start, async abort.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_k = '0;
  logic [3:0]  num_q = '0;
  logic        in_valid = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic        in_ready, busy, done;
  logic [16:0] inst;

  int checks = 0;
  int failures = 0;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_k       (num_k),
    .num_q       (num_q),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Expected instruction word of a stall-free pass; cycle 0 is the start cycle.
  function automatic logic [16:0] exp_inst(input int c, input int K, input int Q);
    logic [16:0] v;
    int b;
    v = '0;
    b = 1;
    if (c >= b && c < b + K) v = 17'(32'h4 | ((c - b) << 12));
    b = b + K;
    if (c >= b && c < b + Q) v = 17'(32'h10 | ((c - b) << 12));
    b = b + Q;
    if (c >= b && c < b + K) v = 17'(32'h48 | ((c - b) << 12));
    b = b + K;
    if (c == b) v = 17'h00040;
    b = b + 1;
    if (c >= b && c < b + Q) v = 17'(32'hA0 | ((c - b) << 12));
    b = b + Q;
    if (c == b) v = 17'h00080;
    b = b + 1;
    if (c >= b && c < b + Q) v = 17'(32'h10001 | ((c - b) << 8));
    return v;
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (inst !== 17'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  // Stall-free pass with both valids tied high
  task automatic test_full(input int nk, input int nq, input string nm);
    int K, Q, dc;
    logic [16:0] e;
    K = nk + 1; Q = nq + 1; dc = 3 + 2 * K + 3 * Q;
    in_valid = 1'b1; ofifo_valid = 1'b1;
    for (int c = 0; c <= dc + 2; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 0) begin num_k = 4'(nk); num_q = 4'(nq); end
      #1;
      e = exp_inst(c, K, Q);
      checks++; if (inst !== e) begin failures++; $display("FAIL %s_inst c=%0d got=%h exp=%h", nm, c, inst, e); end
      checks++; if (busy !== (c >= 1 && c <= dc)) begin failures++; $display("FAIL %s_busy c=%0d got=%b", nm, c, busy); end
      checks++; if (done !== (c == dc)) begin failures++; $display("FAIL %s_done c=%0d got=%b", nm, c, done); end
      checks++; if (in_ready !== (c >= 1 && c < 1 + K + Q)) begin failures++; $display("FAIL %s_in_ready c=%0d got=%b", nm, c, in_ready); end
    end
    start = 1'b0;
  endtask

  // K load with a gappy in_valid pattern
  task automatic test_kstall();
    int vp[7] = '{1, 0, 0, 1, 1, 0, 1};
    int wrs, kw, seen;
    logic [16:0] e;
    wrs = 0; kw = 0; seen = 0;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b1; num_k = 4'd3; num_q = 4'd0; in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = (c == 8) ? 1'b1 : vp[c-1][0];
      #1;
      if (c == 8) e = 17'h00010;
      else e = (vp[c-1] != 0) ? 17'(32'h4 | (wrs << 12)) : 17'(wrs << 12);
      checks++; if (inst !== e) begin failures++; $display("FAIL kstall_inst c=%0d got=%h exp=%h", c, inst, e); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL kstall_in_ready c=%0d got=%b exp=1", c, in_ready); end
      if (inst[2]) kw++;
      if (c < 8 && vp[c-1] != 0) wrs++;
    end
    checks++; if (kw !== 4) begin failures++; $display("FAIL kstall_kwr_count got=%0d exp=4", kw); end
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL kstall_done_timeout got=%0d exp=1", seen); end
    @(negedge clk);
  endtask

  // Drain with ofifo_valid low for 10 cycles, then a gap between handshakes
  task automatic test_drain_stall();
    logic [16:0] e;
    in_valid = 1'b1;
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 0) begin num_k = 4'd0; num_q = 4'd1; end
      ofifo_valid = (c == 19 || c == 21);
      #1;
      if (c <= 8)       e = exp_inst(c, 1, 2);
      else if (c <= 18) e = 17'h0;
      else if (c == 19) e = 17'h10001;
      else if (c == 20) e = 17'h00100;
      else if (c == 21) e = 17'h10101;
      else              e = 17'h0;
      checks++; if (inst !== e) begin failures++; $display("FAIL drain_inst c=%0d got=%h exp=%h", c, inst, e); end
      checks++; if (done !== (c == 22)) begin failures++; $display("FAIL drain_done c=%0d got=%b", c, done); end
      checks++; if (busy !== (c >= 1 && c <= 22)) begin failures++; $display("FAIL drain_busy c=%0d got=%b", c, busy); end
    end
    start = 1'b0;
  endtask

  // Start during EXE and a mid-pass num_k change must not disturb the pass
  task automatic test_ignore();
    int nd;
    logic [16:0] e;
    nd = 0;
    in_valid = 1'b1; ofifo_valid = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 8);
      if (c == 0) begin num_k = 4'd1; num_q = 4'd1; end
      if (c == 2) num_k = 4'd5;
      #1;
      e = exp_inst(c, 2, 2);
      checks++; if (inst !== e) begin failures++; $display("FAIL ignore_inst c=%0d got=%h exp=%h", c, inst, e); end
      checks++; if (done !== (c == 13)) begin failures++; $display("FAIL ignore_done c=%0d got=%b", c, done); end
      if (done === 1'b1) nd++;
    end
    start = 1'b0;
    checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
  endtask

  // Asynchronous reset during KLD, then a fresh minimal pass
  task automatic test_async_reset();
    logic [16:0] e;
    in_valid = 1'b1; ofifo_valid = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 0) begin num_k = 4'd3; num_q = 4'd3; end
      #1;
    end
    checks++; if (inst !== 17'h01048) begin failures++; $display("FAIL areset_pre_inst got=%h exp=01048", inst); end
    #2 reset = 1'b0;
    #1;
    checks++; if (inst !== 17'h0) begin failures++; $display("FAIL areset_inst got=%h exp=0", inst); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (c == 0) begin num_k = 4'd0; num_q = 4'd0; end
      #1;
      e = exp_inst(c, 1, 1);
      checks++; if (inst !== e) begin failures++; $display("FAIL areset_fresh_inst c=%0d got=%h exp=%h", c, inst, e); end
      checks++; if (done !== (c == 8)) begin failures++; $display("FAIL areset_fresh_done c=%0d got=%b", c, done); end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full(7, 7, "full");
    test_kstall();
    test_drain_stall();
    test_ignore();
    test_async_reset();
    test_full(0, 15, "edge");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
